watch_alarm_cu: RTL



---
 rtl/watch_alarm_pkg.sv | 22 ++
 rtl/time_field_cnt.sv | 31 +++
 rtl/watch_alarm_cu.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/watch_alarm_pkg.sv
// Shared types and field limits for the watch alarm controller.
package watch_alarm_pkg;

   localparam int HOUR_W   = 5;
   localparam int MIN_W    = 6;
   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EDIT,
      ST_ARMED,
      ST_RINGING,
      ST_SNOOZE
   } state_t;

   typedef enum logic {
      CUR_MIN  = 1'b0,
      CUR_HOUR = 1'b1
   } cursor_t;

endpackage

// File: rtl/time_field_cnt.sv
// Wrap-around up/down field register (0..MAX) with synchronous load.
module time_field_cnt
   import watch_alarm_pkg::*;
#(
   parameter int W       = MIN_W,
   parameter int MAX     = MIN_MAX,
   parameter int RST_VAL = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] value
);

   // inc and dec together cancel out
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= W'(RST_VAL);
      end else if (load) begin
         value <= load_val;
      end else if (inc && !dec) begin
         value <= (value == W'(MAX)) ? '0 : value + 1'b1;
      end else if (dec && !inc) begin
         value <= (value == '0) ? W'(MAX) : value - 1'b1;
      end
   end

endmodule

// File: rtl/watch_alarm_cu.sv
// Alarm controller: setpoint editing, arming, ringing with blink, snooze and dismiss
// against the running watch time.
module watch_alarm_cu
   import watch_alarm_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BLINK_HZ   = 2,
   parameter int RING_SEC   = 30,
   parameter int SNOOZE_MIN = 5,
   parameter int DEF_HOUR   = 7,
   parameter int DEF_MIN    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_en,
   input  logic              btn_move_p,
   input  logic              btn_up_p,
   input  logic              btn_down_p,
   input  logic              btn_arm_p,
   input  logic [HOUR_W-1:0] i_hour,
   input  logic [MIN_W-1:0]  i_min,
   input  logic [MIN_W-1:0]  i_sec,
   output logic [HOUR_W-1:0] o_alarm_hour,
   output logic [MIN_W-1:0]  o_alarm_min,
   output logic              o_cursor,
   output logic              o_editing,
   output logic              o_armed,
   output logic              o_ring,
   output logic              o_ring_blink
);

   localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
   localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int RC_W  = $clog2(RING_SEC + 1);

   state_t            state, nxt;
   cursor_t           cursor;
   logic              prev_armed;
   logic [MIN_W-1:0]  sec_q;
   logic [RC_W-1:0]   ring_cnt;
   logic [DIV_W-1:0]  div, div_nxt;
   logic              phase, phase_nxt;
   logic [HOUR_W-1:0] snz_hour, snz_hour_nxt, tgt_hour;
   logic [MIN_W-1:0]  snz_min, snz_min_nxt, tgt_min;
   logic [6:0]        snz_sum;
   logic              sec_tick, match, one_dir, edit_step;

   assign sec_tick  = (i_sec != sec_q);
   assign tgt_hour  = (state == ST_SNOOZE) ? snz_hour : o_alarm_hour;
   assign tgt_min   = (state == ST_SNOOZE) ? snz_min  : o_alarm_min;
   assign match     = sec_tick && (i_sec == '0) && (i_hour == tgt_hour) && (i_min == tgt_min);
   assign one_dir   = btn_up_p ^ btn_down_p;
   assign edit_step = (state == ST_EDIT) && i_en && !btn_arm_p && !btn_move_p && one_dir;
   assign o_cursor  = cursor;

   time_field_cnt #(.W(MIN_W), .MAX(MIN_MAX), .RST_VAL(DEF_MIN)) u_min (
      .clk      (clk),
      .reset    (reset),
      .load     (1'b0),
      .load_val ('0),
      .inc      (edit_step && (cursor == CUR_MIN) && btn_up_p),
      .dec      (edit_step && (cursor == CUR_MIN) && btn_down_p),
      .value    (o_alarm_min)
   );

   time_field_cnt #(.W(HOUR_W), .MAX(HOUR_MAX), .RST_VAL(DEF_HOUR)) u_hour (
      .clk      (clk),
      .reset    (reset),
      .load     (1'b0),
      .load_val ('0),
      .inc      (edit_step && (cursor == CUR_HOUR) && btn_up_p),
      .dec      (edit_step && (cursor == CUR_HOUR) && btn_down_p),
      .value    (o_alarm_hour)
   );

   // Snooze target: current time plus SNOOZE_MIN, minute overflow carries into hour
   always_comb begin
      snz_sum = {1'b0, i_min} + 7'(SNOOZE_MIN);
      if (snz_sum > 7'(MIN_MAX)) begin
         snz_min_nxt  = MIN_W'(snz_sum - 7'(MIN_MAX + 1));
         snz_hour_nxt = (i_hour == HOUR_W'(HOUR_MAX)) ? '0 : i_hour + 1'b1;
      end else begin
         snz_min_nxt  = MIN_W'(snz_sum);
         snz_hour_nxt = i_hour;
      end
   end

   // Button priority: arm > move > up/down > time events
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: begin
            if (i_en && btn_arm_p)       nxt = ST_ARMED;
            else if (i_en && btn_move_p) nxt = ST_EDIT;
         end
         ST_EDIT: begin
            if (btn_arm_p)  nxt = ST_ARMED;
            else if (!i_en) nxt = prev_armed ? ST_ARMED : ST_IDLE;
         end
         ST_ARMED: begin
            if (i_en && btn_arm_p)       nxt = ST_IDLE;
            else if (i_en && btn_move_p) nxt = ST_EDIT;
            else if (match)              nxt = ST_RINGING;
         end
         ST_RINGING: begin
            if (btn_arm_p)    nxt = ST_ARMED;
            else if (one_dir) nxt = ST_SNOOZE;
            else if (sec_tick && (ring_cnt == RC_W'(RING_SEC - 1))) nxt = ST_ARMED;
         end
         ST_SNOOZE: begin
            if (btn_arm_p)  nxt = ST_ARMED;
            else if (match) nxt = ST_RINGING;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // Blink divider only runs while staying in RINGING; phase restarts high on entry
   always_comb begin
      div_nxt   = '0;
      phase_nxt = 1'b1;
      if ((state == ST_RINGING) && (nxt == ST_RINGING)) begin
         if (div == DIV_W'(HALF - 1)) begin
            div_nxt   = '0;
            phase_nxt = ~phase;
         end else begin
            div_nxt   = div + 1'b1;
            phase_nxt = phase;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cursor       <= CUR_MIN;
         prev_armed   <= 1'b0;
         sec_q        <= '0;
         ring_cnt     <= '0;
         div          <= '0;
         phase        <= 1'b1;
         o_editing    <= 1'b0;
         o_armed      <= 1'b0;
         o_ring       <= 1'b0;
         o_ring_blink <= 1'b0;
      end else begin
         state        <= nxt;
         sec_q        <= i_sec;
         div          <= div_nxt;
         phase        <= phase_nxt;
         o_editing    <= (nxt == ST_EDIT);
         o_armed      <= (nxt == ST_ARMED) || (nxt == ST_RINGING) || (nxt == ST_SNOOZE);
         o_ring       <= (nxt == ST_RINGING);
         o_ring_blink <= (nxt == ST_RINGING) && phase_nxt;
         if ((state != ST_EDIT) && (nxt == ST_EDIT)) begin
            prev_armed <= (state == ST_ARMED);
            cursor     <= CUR_MIN;
         end else if ((state == ST_EDIT) && (nxt == ST_EDIT) && i_en && btn_move_p) begin
            cursor <= (cursor == CUR_MIN) ? CUR_HOUR : CUR_MIN;
         end
         if ((state != ST_RINGING) && (nxt == ST_RINGING)) begin
            ring_cnt <= '0;
         end else if ((state == ST_RINGING) && sec_tick) begin
            ring_cnt <= ring_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((state == ST_RINGING) && (nxt == ST_SNOOZE)) begin
         snz_hour <= snz_hour_nxt;
         snz_min  <= snz_min_nxt;
      end
   end

endmodule
